// File: rtl/dcache_wb_buffer_pkg.sv
// Shared data-cache definitions: line geometry, AXI burst constants,
// write-back FSM states and the line word-select helper.
package dcache_wb_buffer_pkg;

  localparam int DC_LINE_WORDS = 8;
  localparam int DC_OFFSET_W = $clog2(DC_LINE_WORDS * 4);
  localparam int DC_MAX_WORDS = 16;
  localparam int DC_PAD_W = 32 * DC_MAX_WORDS;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_AW,
    WB_W,
    WB_B
  } wb_state_e;

  function automatic logic [31:0] word_sel(
    input logic [DC_PAD_W-1:0] line,
    input logic [3:0] idx
  );
    return line[{idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_wb_buffer.sv
// Single-entry victim buffer: takes one dirty line, drains it as one
// AXI INCR burst, and lets the cache forward reads from it meanwhile.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [31:0]             push_addr,
  input  logic [32*LINE_WORDS-1:0] push_data,
  input  logic [31:0]             query_addr,
  output logic                    query_hit,
  output logic [31:0]             query_rdata,
  output logic                    wb_empty,
  output logic [31:0]             d_awaddr,
  output logic [7:0]              d_awlen,
  output logic [1:0]              d_awburst,
  output logic [2:0]              d_awsize,
  output logic                    d_awvalid,
  input  logic                    d_awready,
  output logic [31:0]             d_wdata,
  output logic [3:0]              d_wstrb,
  output logic                    d_wlast,
  output logic                    d_wvalid,
  input  logic                    d_wready,
  input  logic                    d_bvalid,
  output logic                    d_bready
);

  localparam int OFFSET_W = $clog2(LINE_WORDS * 4);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  wb_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [32*LINE_WORDS-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DC_PAD_W-1:0] line_pad;
  logic [CNT_W-1:0] q_idx;
  logic busy;
  logic unused_bits;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WB_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WB_IDLE: begin
        if (push_valid) begin
          addr_d  = {push_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
          data_d  = push_data;
          state_d = WB_AW;
        end
      end
      WB_AW: begin
        if (d_awready) begin
          cnt_d   = '0;
          state_d = WB_W;
        end
      end
      WB_W: begin
        if (d_wready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = WB_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WB_B: begin
        if (d_bvalid) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign busy       = (state_q != WB_IDLE);
  assign push_ready = !busy;
  assign wb_empty   = !busy;

  assign d_awaddr  = addr_q;
  assign d_awlen   = 8'(LINE_WORDS - 1);
  assign d_awburst = BURST_INCR;
  assign d_awsize  = SIZE_4B;
  assign d_awvalid = (state_q == WB_AW);

  assign line_pad = DC_PAD_W'(data_q);
  assign d_wdata  = word_sel(line_pad, 4'(cnt_q));
  assign d_wstrb  = 4'hf;
  assign d_wvalid = (state_q == WB_W);
  assign d_wlast  = d_wvalid && (cnt_q == LAST);
  assign d_bready = (state_q == WB_B);

  // Forwarding stays live until the response retires the line.
  assign q_idx = query_addr[OFFSET_W-1:2];
  assign query_hit = busy &&
    (query_addr[31:OFFSET_W] == addr_q[31:OFFSET_W]);
  assign query_rdata = query_hit ?
    word_sel(line_pad, 4'(q_idx)) : 32'h0;

  assign unused_bits = ^{push_addr[OFFSET_W-1:0], query_addr[1:0]};

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Randomized bench for dcache_wb_buffer against a transaction-level
// model of one pending line (address phase, beats sent, response).
module tb_dcache_wb_buffer;

  logic clk = 1'b0;
  logic resetn;
  logic push_valid;
  logic push_ready;
  logic [31:0] push_addr;
  logic [255:0] push_data;
  logic [31:0] query_addr;
  logic query_hit;
  logic [31:0] query_rdata;
  logic wb_empty;
  logic [31:0] d_awaddr;
  logic [7:0] d_awlen;
  logic [1:0] d_awburst;
  logic [2:0] d_awsize;
  logic d_awvalid;
  logic d_awready;
  logic [31:0] d_wdata;
  logic [3:0] d_wstrb;
  logic d_wlast;
  logic d_wvalid;
  logic d_wready;
  logic d_bvalid;
  logic d_bready;

  int nchk = 0;
  int nerr = 0;

  // Model: one pending line, whether its address was sent,
  // how many beats were accepted.
  bit mbusy;
  bit maw;
  int mbeat;
  logic [31:0] maddr;
  logic [31:0] mline [8];
  int nbeats_total;

  always #5 clk = ~clk;

  dcache_wb_buffer #(.LINE_WORDS(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_addr(push_addr),
    .push_data(push_data),
    .query_addr(query_addr),
    .query_hit(query_hit),
    .query_rdata(query_rdata),
    .wb_empty(wb_empty),
    .d_awaddr(d_awaddr),
    .d_awlen(d_awlen),
    .d_awburst(d_awburst),
    .d_awsize(d_awsize),
    .d_awvalid(d_awvalid),
    .d_awready(d_awready),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_wlast(d_wlast),
    .d_wvalid(d_wvalid),
    .d_wready(d_wready),
    .d_bvalid(d_bvalid),
    .d_bready(d_bready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbusy = 0;
    maw = 0;
    mbeat = 0;
  endtask

  // Called at a falling edge with inputs already set; checks outputs,
  // then advances the model over the next rising edge.
  task automatic step();
    bit e_aw, e_w, e_b, e_hit;
    #1;
    e_aw = mbusy && !maw;
    e_w = mbusy && maw && mbeat < 8;
    e_b = mbusy && maw && mbeat == 8;
    e_hit = mbusy && (query_addr[31:5] == maddr[31:5]);
    chk("push_ready", 32'(push_ready), 32'(!mbusy));
    chk("wb_empty", 32'(wb_empty), 32'(!mbusy));
    chk("awvalid", 32'(d_awvalid), 32'(e_aw));
    chk("wvalid", 32'(d_wvalid), 32'(e_w));
    chk("bready", 32'(d_bready), 32'(e_b));
    chk("query_hit", 32'(query_hit), 32'(e_hit));
    chk("query_rdata", query_rdata,
        e_hit ? mline[query_addr[4:2]] : 32'h0);
    if (e_aw) begin
      chk("awaddr", d_awaddr, maddr);
      chk("awlen", 32'(d_awlen), 32'd7);
      chk("awburst", 32'(d_awburst), 32'd1);
      chk("awsize", 32'(d_awsize), 32'd2);
    end
    if (e_w) begin
      chk("wdata", d_wdata, mline[mbeat]);
      chk("wlast", 32'(d_wlast), 32'(mbeat == 7));
      chk("wstrb", 32'(d_wstrb), 32'hf);
    end else begin
      chk("wlast_idle", 32'(d_wlast), 32'd0);
    end
    if (!mbusy && push_valid) begin
      mbusy = 1;
      maw = 0;
      mbeat = 0;
      maddr = push_addr & 32'hffff_ffe0;
      for (int i = 0; i < 8; i++) mline[i] = push_data[32*i +: 32];
    end else if (e_aw && d_awready) begin
      maw = 1;
    end else if (e_w && d_wready) begin
      mbeat++;
      nbeats_total++;
    end else if (e_b && d_bvalid) begin
      mbusy = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  initial begin
    int s2, s7, aw_low, cyc, beats0;
    resetn = 0;
    push_valid = 0;
    push_addr = 0;
    push_data = 0;
    query_addr = 32'h1000_0000;
    d_awready = 0;
    d_wready = 0;
    d_bvalid = 0;
    model_reset();
    nbeats_total = 0;
    repeat (2) @(negedge clk);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    chk("rst_hit", 32'(query_hit), 32'd0);
    chk("rst_awvalid", 32'(d_awvalid), 32'd0);
    chk("rst_wvalid", 32'(d_wvalid), 32'd0);
    chk("rst_wlast", 32'(d_wlast), 32'd0);
    chk("rst_bready", 32'(d_bready), 32'd0);
    resetn = 1;
    @(negedge clk);

    // Basic drain with everything ready, plus queries during W.
    push_valid = 1;
    push_addr = 32'h1000_0014;
    push_data = seq_line(32'hA0);
    d_awready = 1;
    d_wready = 1;
    d_bvalid = 1;
    step();
    push_valid = 0;
    cyc = 0;
    while (mbusy && cyc < 30) begin
      query_addr = cyc[0] ? 32'h1000_0018 : 32'h1000_0020;
      step();
      cyc++;
    end
    chk("drain_done", 32'(mbusy), 32'd0);
    query_addr = 32'h1000_0000;
    step();

    // W backpressure at beats 2 and 7.
    push_valid = 1;
    push_addr = 32'h1000_0040;
    push_data = seq_line(32'hA0);
    step();
    push_valid = 0;
    s2 = 0;
    s7 = 0;
    cyc = 0;
    beats0 = nbeats_total;
    query_addr = 32'h1000_0058;
    while (mbusy && cyc < 40) begin
      d_wready = 1;
      if (maw && mbeat == 2 && s2 < 3) begin
        d_wready = 0;
        s2++;
      end else if (maw && mbeat == 7 && s7 < 1) begin
        d_wready = 0;
        s7++;
      end
      step();
      cyc++;
    end
    chk("bp_beats", 32'(nbeats_total - beats0), 32'd8);
    d_wready = 1;

    // Push held while busy, slow awready, early bvalid pulse.
    push_valid = 1;
    push_addr = 32'h2000_0000;
    push_data = seq_line(32'hB0);
    d_bvalid = 0;
    aw_low = 0;
    cyc = 0;
    step();
    push_addr = 32'h3000_0020;
    push_data = seq_line(32'hC0);
    while (mbusy && cyc < 60) begin
      d_awready = !(maw == 0 && aw_low < 5);
      if (!maw) aw_low++;
      d_bvalid = (maw && mbeat == 3) || (maw && mbeat == 8 && cyc[1]);
      query_addr = {maddr[31:5], 5'($urandom)};
      step();
      cyc++;
    end
    chk("busy_done", 32'(mbusy), 32'd0);
    d_bvalid = 0;
    step();
    chk("second_accepted", 32'(mbusy), 32'd1);
    push_valid = 0;
    d_awready = 1;
    step();

    // Reset while beat 4 is on the bus.
    cyc = 0;
    while (!(maw && mbeat == 4) && cyc < 40) begin
      step();
      cyc++;
    end
    query_addr = 32'h3000_0024;
    resetn = 0;
    #1;
    chk("arst_wvalid", 32'(d_wvalid), 32'd0);
    chk("arst_push_ready", 32'(push_ready), 32'd1);
    chk("arst_wb_empty", 32'(wb_empty), 32'd1);
    chk("arst_hit", 32'(query_hit), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    @(negedge clk);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      push_valid = ($urandom % 3) == 0;
      push_addr = $urandom;
      for (int i = 0; i < 8; i++) push_data[32*i +: 32] = $urandom;
      d_awready = ($urandom % 3) != 0;
      d_wready = ($urandom % 4) != 0;
      d_bvalid = ($urandom % 3) == 0;
      if ($urandom % 2) query_addr = {maddr[31:5], 5'($urandom)};
      else query_addr = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Single-entry write-back (victim) buffer between the data cache and the AXI arbiter's d_aw/d_w/d_b channels.
- Accepts one evicted dirty line in a single cycle and frees the cache immediately.
- Drains the line to the arbiter as one INCR write burst, then waits for the write response.
- Exposes an address-match query so the cache can forward data from the buffered line instead of reading stale memory.

Parameters:
- LINE_WORDS, 8: 32-bit words per cache line. Power of two, 2..16, because the burst length is truncated to 4 bits downstream.
- OFFSET_W, log2(LINE_WORDS*4): localparam, byte-offset width of a line.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- push_valid  in  1  cache offers an evicted line
- push_ready  out  1  buffer can accept a line
- push_addr  in  32  line address; low OFFSET_W bits are ignored and forced to 0
- push_data  in  32*LINE_WORDS  line data; word i is in bits [32i+31:32i]
- query_addr  in  32  byte address probed by the cache on a read miss
- query_hit  out  1  buffered line matches query_addr
- query_rdata  out  32  word of the buffered line selected by query_addr[OFFSET_W-1:2]
- wb_empty  out  1  no line pending
- d_awaddr  out  32  burst address
- d_awlen  out  8  LINE_WORDS-1
- d_awburst  out  2  2'b01 (INCR)
- d_awsize  out  3  3'b010 (4 bytes)
- d_awvalid  out  1  write-address valid
- d_awready  in  1  write-address ready
- d_wdata  out  32  beat data
- d_wstrb  out  4  always 4'hf
- d_wlast  out  1  final beat
- d_wvalid  out  1  write-data valid
- d_wready  in  1  write-data ready
- d_bvalid  in  1  write-response valid
- d_bready  out  1  write-response ready

Behaviour:
- FSM states: IDLE, AW, W, B. State, line registers and beat counter are all registered.
- Reset: state=IDLE, beat counter=0, line valid=0.
- Reset values of outputs: push_ready=1, wb_empty=1, query_hit=0, d_awvalid=0, d_wvalid=0, d_wlast=0, d_bready=0. Data and address outputs are don't-care but are driven from registers.
- push_ready = (state==IDLE).
- On push_valid&push_ready: capture the address (low bits zeroed) and the data, then go to AW. d_awvalid is high in the next cycle, so accept-to-awvalid latency is 1 cycle.
- AW: d_awvalid=1. Hold until d_awready=1, then go to W with the beat counter at 0. d_awaddr/len/burst/size stay stable while d_awvalid is high.
- W: d_wvalid=1, d_wdata=word[cnt], d_wlast=(cnt==LINE_WORDS-1).
  - On d_wready, cnt increments.
  - On the d_wlast beat accepted, go to B and clear cnt.
  - With d_wready low, hold the beat unchanged with no bubble.
  - Beats issue back-to-back when d_wready stays high.
- B: d_bready=1. On d_bvalid, go to IDLE. No response code is checked (the arbiter does not forward one).
- d_bvalid outside state B is ignored, since d_bready=0.
- wb_empty = (state==IDLE).
- query_hit (combinational) = (state!=IDLE) && query_addr[31:OFFSET_W]==stored_addr[31:OFFSET_W].
  - query_rdata = stored word at query_addr[OFFSET_W-1:2] when query_hit=1, 0 otherwise.
  - query_hit stays valid through the d_bvalid cycle and drops the cycle after.
- No push is accepted in the same cycle the B handshake completes. The earliest new accept is the cycle after.
- Reset asserted mid-burst: the burst is abandoned, all valids drop asynchronously, and the line is discarded. Resetting the interconnect is the system's responsibility.
- No skid logic is needed: at most one outstanding transaction, and a single AXI ID is handled by the arbiter.

Decomposition:
- Shared cache package:
  - LINE_WORDS and the OFFSET_W derivation
  - AXI constants BURST_INCR=2'b01 and SIZE_4B=3'b010
  - FSM state enum {WB_IDLE, WB_AW, WB_W, WB_B}
- No sub-module. Word selection for d_wdata and query_rdata is one shared mux function in the package, not a separate module.

Test Plan:
- Basic drain:
  - Stimulus: push addr 0x1000_0014, data words 0..7 = 0xA0..0xA7; d_awready, d_wready and d_bvalid all tied high.
  - Required: d_awaddr=0x1000_0000 and d_awlen=7, then 8 consecutive beats 0xA0..0xA7 with d_wlast only on 0xA7. wb_empty=1 the cycle after the B handshake.
- W backpressure:
  - Stimulus: d_wready low for 3 cycles at beat 2 and low for 1 cycle at beat 7.
  - Required: d_wdata holds 0xA2 and then 0xA7 while stalled, with d_wvalid=1 throughout. Exactly 8 beats are accepted.
- Query:
  - Stimulus: while in W, query 0x1000_0018, then 0x1000_0020.
  - Required: first query gives hit=1 and rdata=0xA6; second gives hit=0 and rdata=0. Query 0x1000_0000 after the B handshake gives hit=0.
- Push while busy:
  - Stimulus: push_valid held high during AW/W/B.
  - Required: push_ready=0 until the cycle after d_bvalid. The second line is then accepted and its d_awvalid appears 1 cycle later.
- Early bvalid and delayed awready:
  - Stimulus: d_bvalid pulsed during W; d_awready held low for 5 cycles.
  - Required: d_awvalid stable for 5 cycles, the pulse is ignored, and the FSM completes only on the later d_bvalid in B.
- Reset mid-burst:
  - Stimulus: resetn low at beat 4.
  - Required: d_wvalid=0, push_ready=1, wb_empty=1 and query_hit=0 immediately (asynchronously).
